// File: rtl/digi_pattern_source.sv
// digi_pattern_source
//   Emits a stored LEN-bit pattern on y, LSB first, holding each bit for DIV
//   clock cycles. A pass either completes (done pulse) or, with rpt high at
//   the end of the last bit, wraps straight back to bit 0 with no gap.
//
// Parameters
//   LEN  : pattern length in bits (2..64)
//   DIV  : clock cycles each bit is held (1..256)
//   INIT : level driven on y while not running
//
// Ports
//   clk      : clock, all state changes on its rising edge
//   rst_n    : asynchronous active-low reset
//   pattern  : pattern to capture on load
//   load     : capture pattern into the store (IDLE only)
//   start    : begin emission (IDLE only)
//   stop     : abort emission, returns to IDLE without done
//   rpt      : repeat the pattern continuously
//   y        : registered stimulus output
//   busy     : high while running
//   done     : one-cycle pulse when a non-repeating pass completes
//   bit_idx  : index of the bit currently on y
//   loop_cnt : (only with DIGI_SRC_LOOPCNT_EN) saturating count of wraps
//
// Optional feature macro: DIGI_SRC_LOOPCNT_EN adds the loop_cnt output.

module digi_pattern_source #(
    parameter int   LEN  = 16,
    parameter int   DIV  = 1,
    parameter logic INIT = 1'b0,
    localparam int  IW   = (LEN > 1) ? $clog2(LEN) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [LEN-1:0] pattern,
    input  logic           load,
    input  logic           start,
    input  logic           stop,
    input  logic           rpt,
    output logic           y,
    output logic           busy,
    output logic           done,
    output logic [IW-1:0]  bit_idx
`ifdef DIGI_SRC_LOOPCNT_EN
    ,
    output logic [7:0]     loop_cnt
`endif
);

    localparam int            DW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);
    localparam logic [DW-1:0] LAST_DIV = DW'(DIV - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state_reg;
    logic [LEN-1:0] store_reg;
    logic [DW-1:0]  div_cnt_reg;
    logic [IW-1:0]  idx_next;

    // Only used when bit_idx is below LAST_IDX, so it never overflows in use.
    assign idx_next = bit_idx + IW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            store_reg   <= '0;
            div_cnt_reg <= '0;
            y           <= INIT;
            busy        <= 1'b0;
            done        <= 1'b0;
            bit_idx     <= '0;
`ifdef DIGI_SRC_LOOPCNT_EN
            loop_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (load) begin
                        store_reg <= pattern;
                    end
                    // stop together with start keeps the block idle.
                    if (start && !stop) begin
                        state_reg   <= RUN;
                        // Same-cycle load must take effect for the first bit.
                        y           <= load ? pattern[0] : store_reg[0];
                        bit_idx     <= '0;
                        div_cnt_reg <= '0;
                        busy        <= 1'b1;
`ifdef DIGI_SRC_LOOPCNT_EN
                        loop_cnt    <= '0;
`endif
                    end
                end
                RUN: begin
                    if (stop) begin
                        // Abort wins over advance, wrap and completion.
                        state_reg   <= IDLE;
                        y           <= INIT;
                        busy        <= 1'b0;
                        bit_idx     <= '0;
                        div_cnt_reg <= '0;
                    end else if (div_cnt_reg == LAST_DIV) begin
                        div_cnt_reg <= '0;
                        if (bit_idx == LAST_IDX) begin
                            if (rpt) begin
                                bit_idx <= '0;
                                y       <= store_reg[0];
`ifdef DIGI_SRC_LOOPCNT_EN
                                if (loop_cnt != 8'hFF) begin
                                    loop_cnt <= loop_cnt + 8'd1;
                                end
`endif
                            end else begin
                                state_reg <= IDLE;
                                y         <= INIT;
                                busy      <= 1'b0;
                                done      <= 1'b1;
                                bit_idx   <= '0;
                            end
                        end else begin
                            bit_idx <= idx_next;
                            y       <= store_reg[idx_next];
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + DW'(1);
                    end
                end
            endcase
        end
    end

endmodule
